// File: rtl/relojes_pkg.sv
// Shared definitions for the divided-clock checker: FSM states,
// err_code bit positions and the default divider ratios.
package relojes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACQ    = 2'd1,
      ST_LOCKED = 2'd2,
      ST_ERROR  = 2'd3
   } state_t;

   // err_code bit positions
   localparam int ERR_CLK4  = 0;
   localparam int ERR_CLK2  = 1;
   localparam int ERR_CLK   = 2;
   localparam int ERR_PHASE = 3;

   // Default divider ratios, in clk32f cycles
   localparam int DIV4_DEF  = 8;
   localparam int DIV2_DEF  = 16;
   localparam int DIV1_DEF  = 32;
   localparam int LOCKN_DEF = 2;
   localparam int CW_DEF    = 7;

   // Width of the consecutive-good-period counter
   localparam int GOOD_W = 4;

endpackage

// File: rtl/verif_relojes_per_chk.sv
// Per-channel checker: samples one divided clock, detects its edges and
// flags a bad period, a bad high time or a stopped clock.
module per_chk #(
   parameter int DIV = 8,
   parameter int CW  = 7
) (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic rise,
   output logic fail,
   output logic seen
);

   localparam logic [CW-1:0] MAX_C   = '1;
   localparam logic [CW-1:0] DIV_C   = CW'(DIV);
   localparam logic [CW-1:0] HALF_C  = CW'(DIV / 2);
   localparam logic [CW-1:0] STUCK_C = CW'(2 * DIV);

   logic          q;
   logic          p;
   logic          fall;
   logic [CW-1:0] cnt;
   logic [CW-1:0] hcnt;

   assign rise = q & ~p;
   assign fall = ~q & p;

   // Sampler, edge history, saturating period/high counters and first-rise flag
   always_ff @(posedge clk) begin
      if (reset) begin
         q    <= 1'b0;
         p    <= 1'b0;
         cnt  <= '0;
         hcnt <= '0;
         seen <= 1'b0;
      end else begin
         q <= sig;
         p <= q;
         if (rise)
            cnt <= CW'(1);
         else if (cnt != MAX_C)
            cnt <= CW'(cnt + 1'b1);
         if (!q)
            hcnt <= '0;
         else if (hcnt != MAX_C)
            hcnt <= CW'(hcnt + 1'b1);
         if (rise)
            seen <= 1'b1;
      end
   end

   // A channel fails on a wrong period at a rise, a wrong high time at a fall,
   // or whenever too long has passed since the last rise
   always_comb begin
      fail = seen & ((rise & (cnt != DIV_C)) |
                     (fall & (hcnt != HALF_C)) |
                     (cnt > STUCK_C));
   end

endmodule

// File: rtl/verif_relojes.sv
// Checker for the clock divider outputs: per-channel period/duty checks,
// mutual phase check and a lock/error FSM with sticky error codes.
module verif_relojes
   import relojes_pkg::*;
#(
   parameter int DIV4  = DIV4_DEF,
   parameter int DIV2  = DIV2_DEF,
   parameter int DIV1  = DIV1_DEF,
   parameter int LOCKN = LOCKN_DEF,
   parameter int CW    = CW_DEF
) (
   input  logic       clk32f,
   input  logic       reset,
   input  logic       clk4f,
   input  logic       clk2f,
   input  logic       clk,
   output logic       locked,
   output logic       error,
   output logic [3:0] err_code,
   output logic [1:0] state
);

   logic rise4, rise2, rise1;
   logic fail4, fail2, fail1;
   logic seen4, seen2, seen1;
   logic phase_fail;
   logic [3:0] chan_fail;

   state_t            state_r, state_nxt;
   logic [GOOD_W-1:0] good, good_nxt;
   logic [3:0]        err_nxt;

   per_chk #(.DIV(DIV4), .CW(CW)) u_chk4 (
      .clk(clk32f), .reset(reset), .sig(clk4f),
      .rise(rise4), .fail(fail4), .seen(seen4)
   );

   per_chk #(.DIV(DIV2), .CW(CW)) u_chk2 (
      .clk(clk32f), .reset(reset), .sig(clk2f),
      .rise(rise2), .fail(fail2), .seen(seen2)
   );

   per_chk #(.DIV(DIV1), .CW(CW)) u_chk1 (
      .clk(clk32f), .reset(reset), .sig(clk),
      .rise(rise1), .fail(fail1), .seen(seen1)
   );

   // Every slower rise must coincide with a rise of each faster clock
   always_comb begin
      phase_fail = (rise1 & ~(rise2 & rise4)) | (rise2 & ~rise4);
      chan_fail  = '0;
      chan_fail[ERR_CLK4]  = fail4;
      chan_fail[ERR_CLK2]  = fail2;
      chan_fail[ERR_CLK]   = fail1;
      chan_fail[ERR_PHASE] = phase_fail;
   end

   // Next-state logic; a rise detected this cycle counts as seen so the
   // first aligned rise of all three clocks can start acquisition, and a
   // failure restarts the good count so the next clean clk rise is the first
   always_comb begin
      state_nxt = state_r;
      good_nxt  = good;
      err_nxt   = err_code;
      case (state_r)
         ST_IDLE: begin
            good_nxt = '0;
            if (rise1 && (seen4 || rise4) && (seen2 || rise2) && (seen1 || rise1))
               state_nxt = ST_ACQ;
         end
         ST_ACQ: begin
            if (|chan_fail)
               good_nxt = '0;
            else if (good >= GOOD_W'(LOCKN))
               state_nxt = ST_LOCKED;
            else if (rise1)
               good_nxt = GOOD_W'(good + 1'b1);
         end
         ST_LOCKED: begin
            if (|chan_fail) begin
               state_nxt = ST_ERROR;
               err_nxt   = chan_fail;
            end
         end
         ST_ERROR: begin
            err_nxt = err_code | chan_fail;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State, good counter and error code registers
   always_ff @(posedge clk32f) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         good     <= '0;
         err_code <= '0;
      end else begin
         state_r  <= state_nxt;
         good     <= good_nxt;
         err_code <= err_nxt;
      end
   end

   // Status flags follow the state register one cycle later
   always_ff @(posedge clk32f) begin
      if (reset) begin
         locked <= 1'b0;
         error  <= 1'b0;
      end else begin
         locked <= (state_r == ST_LOCKED);
         error  <= (state_r == ST_ERROR);
      end
   end

   assign state = state_r;

endmodule

// File: tb/tb_verif_relojes.sv
// Directed bench for verif_relojes: drives ideal and deliberately damaged
// divided clocks and checks lock timing, error codes and reset recovery.
module tb_verif_relojes;

   logic       clk32f = 1'b0;
   logic       reset;
   logic       clk4f;
   logic       clk2f;
   logic       clk;
   logic       locked;
   logic       error;
   logic [3:0] err_code;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;
   int cyc;
   int f4_from;
   int f4_to;
   logic f4_val;
   int kill2_from;
   int delay1;

   always #5 clk32f = ~clk32f;

   verif_relojes dut (
      .clk32f(clk32f),
      .reset(reset),
      .clk4f(clk4f),
      .clk2f(clk2f),
      .clk(clk),
      .locked(locked),
      .error(error),
      .err_code(err_code),
      .state(state)
   );

   // One comparison point
   task automatic check_output(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s at cyc %0d observed %0h expected %0h", tag, cyc - 1, obs, exp);
      end
   endtask

   // Drive pins for the current cycle index, then advance one clk32f cycle
   task automatic apply_stimulus();
      int d;
      clk4f = (cyc >= f4_from && cyc <= f4_to) ? f4_val : ~cyc[2];
      clk2f = (kill2_from >= 0 && cyc >= kill2_from) ? 1'b0 : ~cyc[3];
      if (cyc < delay1) begin
         clk = 1'b0;
      end else begin
         d   = cyc - delay1;
         clk = ~d[4];
      end
      @(posedge clk32f);
      #1;
      cyc++;
   endtask

   // Advance until the window after edge n has been reached
   task automatic run_to(input int n);
      while (cyc <= n) apply_stimulus();
   endtask

   task automatic clear_mods();
      f4_from    = -1;
      f4_to      = -2;
      f4_val     = 1'b0;
      kill2_from = -1;
      delay1     = 0;
   endtask

   // Reset for n cycles, confirm cleared outputs, restart aligned clocks
   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) begin
         @(posedge clk32f);
         #1;
      end
      check_output("rst_locked", {3'b0, locked}, 4'd0);
      check_output("rst_error", {3'b0, error}, 4'd0);
      check_output("rst_err_code", err_code, 4'd0);
      check_output("rst_state", {2'b0, state}, 4'd0);
      reset = 1'b0;
      cyc   = 0;
      clear_mods();
   endtask

   initial begin
      reset = 1'b1;
      clk4f = 1'b0;
      clk2f = 1'b0;
      clk   = 1'b0;
      cyc   = 0;
      clear_mods();

      $display("[TB] test 1: ideal clocks lock");
      do_reset(3);
      run_to(1);
      check_output("t1_acq", {2'b0, state}, 4'd1);
      run_to(66);
      check_output("t1_state_locked", {2'b0, state}, 4'd2);
      check_output("t1_locked_lag", {3'b0, locked}, 4'd0);
      run_to(67);
      check_output("t1_locked", {3'b0, locked}, 4'd1);
      check_output("t1_error", {3'b0, error}, 4'd0);
      check_output("t1_err_code", err_code, 4'd0);

      $display("[TB] test 2: stretched clk4f high pulse");
      f4_from = 96;
      f4_to   = 100;
      f4_val  = 1'b1;
      run_to(101);
      check_output("t2_before", {2'b0, state}, 4'd2);
      run_to(102);
      check_output("t2_state", {2'b0, state}, 4'd3);
      check_output("t2_code", err_code, 4'b0001);
      run_to(103);
      check_output("t2_locked", {3'b0, locked}, 4'd0);
      check_output("t2_error", {3'b0, error}, 4'd1);
      run_to(200);
      check_output("t2_code_hold", err_code, 4'b0001);

      $display("[TB] test 3: clk2f held low");
      do_reset(2);
      kill2_from = 104;
      run_to(67);
      check_output("t3_locked", {3'b0, locked}, 4'd1);
      run_to(128);
      check_output("t3_still_locked", {2'b0, state}, 4'd2);
      run_to(129);
      check_output("t3_phase_code", err_code, 4'b1000);
      run_to(130);
      check_output("t3_stuck_code", err_code, 4'b1010);
      check_output("t3_error", {3'b0, error}, 4'd1);
      check_output("t3_unlocked", {3'b0, locked}, 4'd0);
      run_to(400);
      check_output("t3_error_hold", {3'b0, error}, 4'd1);
      check_output("t3_code_hold", err_code, 4'b1010);

      $display("[TB] test 4: clk delayed by 8 cycles");
      do_reset(2);
      delay1 = 8;
      run_to(9);
      check_output("t4_acq", {2'b0, state}, 4'd1);
      for (int k = 1; k <= 20; k++) begin
         run_to(8 + 32 * k + 2);
         check_output("t4_no_lock", {2'b0, error, locked}, 4'd0);
      end
      check_output("t4_state_acq", {2'b0, state}, 4'd1);
      check_output("t4_err_code", err_code, 4'd0);

      $display("[TB] test 5: clk4f glitch during acquisition");
      do_reset(2);
      f4_from = 44;
      f4_to   = 44;
      f4_val  = 1'b1;
      run_to(67);
      check_output("t5_not_yet", {2'b0, state, locked}, 4'b0010);
      run_to(98);
      check_output("t5_state", {2'b0, state}, 4'd2);
      check_output("t5_locked_lag", {3'b0, locked}, 4'd0);
      run_to(99);
      check_output("t5_locked", {3'b0, locked}, 4'd1);
      check_output("t5_error", {3'b0, error}, 4'd0);

      $display("[TB] test 6: reset out of ERROR");
      do_reset(2);
      f4_from = 96;
      f4_to   = 99;
      f4_val  = 1'b0;
      run_to(97);
      check_output("t6_phase", err_code, 4'b1000);
      run_to(106);
      check_output("t6_code", err_code, 4'b1001);
      check_output("t6_error", {3'b0, error}, 4'd1);
      do_reset(1);
      run_to(66);
      check_output("t6_relock_lag", {3'b0, locked}, 4'd0);
      run_to(67);
      check_output("t6_relocked", {3'b0, locked}, 4'd1);
      check_output("t6_relock_code", err_code, 4'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
